// File: rtl/bullcow_display.sv
// Bulls-and-Cows display stage: scans an 8-digit common-anode 7-seg display
// showing live score, a held guess result, or a blinking winner banner.
module bullcow_display #(
  parameter int SCAN_DIV     = 100000,
  parameter int HOLD_CYCLES  = 200000000,
  parameter int WIN_CYCLES   = 400000000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            result_valid,
  input  logic            player,
  input  logic [2:0]      bulls,
  input  logic [2:0]      cows,
  input  logic            game_over,
  input  logic            winner,
  input  logic [1:0][7:0] points,
  output logic [7:0]      an,
  output logic [7:0]      dec_cat
);

  localparam logic [1:0] SCORE  = 2'd0;
  localparam logic [1:0] RESULT = 2'd1;
  localparam logic [1:0] WIN    = 2'd2;

  localparam int SW = $clog2(SCAN_DIV);
  localparam int TMAX = (WIN_CYCLES > HOLD_CYCLES) ? WIN_CYCLES : HOLD_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  logic [1:0]    mode_q, mode_d;
  logic [2:0]    idx_q, idx_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [2:0]    bulls_q, bulls_d;
  logic [2:0]    cows_q, cows_d;
  logic          player_q, player_d;
  logic          winner_q, winner_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [11:0]   bcd0, bcd1;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // Counts above 4 are impossible in a real game; show them as a dash.
  function automatic logic [7:0] bc_seg(input logic [2:0] v);
    return (v > 3'd4) ? 8'hBF : seg7({1'b0, v});
  endfunction

  function automatic logic [11:0] bin2bcd(input logic [7:0] b);
    logic [11:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
      if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
      r = {r[10:0], b[i]};
    end
    return r;
  endfunction

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    timer_d  = timer_q;
    bcnt_d   = bcnt_q;
    blink_d  = blink_q;
    bulls_d  = bulls_q;
    cows_d   = cows_q;
    player_d = player_q;
    winner_d = winner_q;
    if (mode_q == WIN) begin
      if (bcnt_q == BW'(BLINK_CYCLES - 1)) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    if (game_over) begin
      mode_d   = WIN;
      winner_d = winner;
      timer_d  = TW'(WIN_CYCLES - 1);
      bcnt_d   = '0;
      blink_d  = 1'b1;
    end else if (result_valid && mode_q != WIN) begin
      mode_d   = RESULT;
      bulls_d  = bulls;
      cows_d   = cows;
      player_d = player;
      timer_d  = TW'(HOLD_CYCLES - 1);
    end else if (mode_q != SCORE) begin
      if (timer_q == '0) mode_d = SCORE;
      else timer_d = timer_q - 1'b1;
    end
  end

  always_comb begin
    bcd0  = bin2bcd(points[0]);
    bcd1  = bin2bcd(points[1]);
    seg_d = 8'hFF;
    case (mode_q)
      RESULT: begin
        unique case (idx_q)
          3'd7: seg_d = 8'hE1;
          3'd6: seg_d = seg7({3'b0, player_q} + 4'd1);
          3'd5: seg_d = 8'hFF;
          3'd4: seg_d = 8'h83;
          3'd3: seg_d = bc_seg(bulls_q);
          3'd2: seg_d = 8'hFF;
          3'd1: seg_d = 8'hA7;
          3'd0: seg_d = bc_seg(cows_q);
        endcase
      end
      WIN: begin
        unique case (idx_q)
          3'd7:    seg_d = 8'hE1;
          3'd6:    seg_d = seg7({3'b0, winner_q} + 4'd1);
          default: seg_d = 8'hBF;
        endcase
      end
      default: begin
        unique case (idx_q)
          3'd7: seg_d = 8'hF9;
          3'd6: seg_d = seg7(bcd0[11:8]);
          3'd5: seg_d = seg7(bcd0[7:4]);
          3'd4: seg_d = seg7(bcd0[3:0]);
          3'd3: seg_d = 8'hA4;
          3'd2: seg_d = seg7(bcd1[11:8]);
          3'd1: seg_d = seg7(bcd1[7:4]);
          3'd0: seg_d = seg7(bcd1[3:0]);
        endcase
      end
    endcase
    an_d = (mode_q == WIN && !blink_q) ? 8'hFF : ~(8'd1 << idx_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= SCORE;
      idx_q    <= '0;
      scan_q   <= '0;
      timer_q  <= '0;
      bcnt_q   <= '0;
      blink_q  <= 1'b1;
      bulls_q  <= '0;
      cows_q   <= '0;
      player_q <= 1'b0;
      winner_q <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      mode_q   <= mode_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      timer_q  <= timer_d;
      bcnt_q   <= bcnt_d;
      blink_q  <= blink_d;
      bulls_q  <= bulls_d;
      cows_q   <= cows_d;
      player_q <= player_d;
      winner_q <= winner_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an      = an_q;
  assign dec_cat = seg_q;

endmodule

// File: tb/tb_bullcow_display.sv
// Bench for bullcow_display: directed phases then random pulses, checked
// against a cycle-stamp model of the display modes.
module tb_bullcow_display;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 20;
  localparam int WINC     = 40;
  localparam int BLINK    = 8;

  localparam int K_SCORE  = 0;
  localparam int K_RESULT = 1;
  localparam int K_WIN    = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            result_valid = 1'b0;
  logic            player = 1'b0;
  logic [2:0]      bulls = '0;
  logic [2:0]      cows = '0;
  logic            game_over = 1'b0;
  logic            winner = 1'b0;
  logic [1:0][7:0] points = '0;
  logic [7:0]      an;
  logic [7:0]      dec_cat;

  logic [7:0] p0 = '0;
  logic [7:0] p1 = '0;

  int n_vec = 0;
  int n_bad = 0;
  int k = 0;

  int m_kind = K_SCORE;
  int m_j = 0;
  int m_pl = 0;
  int m_b = 0;
  int m_c = 0;
  int m_w = 0;

  logic [7:0] DIG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  bullcow_display #(
    .SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD),
    .WIN_CYCLES(WINC), .BLINK_CYCLES(BLINK)
  ) dut (
    .clock(clock), .reset(reset),
    .result_valid(result_valid), .player(player),
    .bulls(bulls), .cows(cows),
    .game_over(game_over), .winner(winner),
    .points(points), .an(an), .dec_cat(dec_cat)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic int mode_at(input int kk);
    if (m_kind == K_RESULT && kk - m_j <= HOLD) return K_RESULT;
    if (m_kind == K_WIN && kk - 1 - m_j < WINC) return K_WIN;
    return K_SCORE;
  endfunction

  function automatic logic [7:0] bc(input int v);
    return (v > 4) ? 8'hBF : DIG[v];
  endfunction

  function automatic logic [7:0] glyph(input int md, input int pos);
    logic [7:0] g [8];
    int a;
    int b;
    a = int'(p0);
    b = int'(p1);
    if (md == K_RESULT) begin
      g[7] = 8'hE1; g[6] = DIG[m_pl + 1]; g[5] = 8'hFF; g[4] = 8'h83;
      g[3] = bc(m_b); g[2] = 8'hFF; g[1] = 8'hA7; g[0] = bc(m_c);
    end else if (md == K_WIN) begin
      for (int i = 0; i < 6; i++) g[i] = 8'hBF;
      g[7] = 8'hE1; g[6] = DIG[m_w + 1];
    end else begin
      g[7] = DIG[1]; g[6] = DIG[a / 100];
      g[5] = DIG[(a / 10) % 10]; g[4] = DIG[a % 10];
      g[3] = DIG[2]; g[2] = DIG[b / 100];
      g[1] = DIG[(b / 10) % 10]; g[0] = DIG[b % 10];
    end
    return g[pos];
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    result_valid = 1'b0;
    game_over = 1'b0;
    @(posedge clock);
    #1;
    check("reset_an", an, 8'hFF);
    check("reset_seg", dec_cat, 8'hFF);
    k = 0;
    m_kind = K_SCORE;
    m_j = 0;
  endtask

  task automatic step(input logic rv, input logic pl,
                      input logic [2:0] b, input logic [2:0] c,
                      input logic go, input logic w);
    logic [7:0] ea;
    logic [7:0] ed;
    int pos;
    int md;
    @(negedge clock);
    reset = 1'b0;
    result_valid = rv;
    player = pl;
    bulls = b;
    cows = c;
    game_over = go;
    winner = w;
    points[0] = p0;
    points[1] = p1;
    pos = (k / SCAN_DIV) % 8;
    md = mode_at(k);
    if (md == K_WIN && ((k - 1 - m_j) / BLINK) % 2 == 1) ea = 8'hFF;
    else ea = 8'(~(8'd1 << pos));
    ed = glyph(md, pos);
    if (go) begin
      m_kind = K_WIN; m_j = k; m_w = int'(w);
    end else if (rv && md != K_WIN) begin
      m_kind = K_RESULT; m_j = k;
      m_pl = int'(pl); m_b = int'(b); m_c = int'(c);
    end
    @(posedge clock);
    #1;
    check($sformatf("an@%0d", k), an, ea);
    check($sformatf("seg@%0d", k), dec_cat, ed);
    k++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
  endtask

  initial begin
    do_reset();
    idle(32);
    p0 = 8'd255; p1 = 8'd7;
    idle(32);
    step(1'b1, 1'b1, 3'd2, 3'd1, 1'b0, 1'b0);
    idle(9);
    step(1'b1, 1'b1, 3'd0, 3'd1, 1'b0, 1'b0);
    idle(30);
    step(1'b1, 1'b0, 3'd5, 3'd6, 1'b0, 1'b0);
    idle(25);
    step(1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0);
    idle(45);
    step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1);
    idle(12);
    do_reset();
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 49) == 0) begin
          p0 = 8'($urandom_range(0, 255));
          p1 = 8'($urandom_range(0, 255));
        end
        step(1'($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 1)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
